serial_stream_feeder: RTL

SERIAL_STREAM_FEEDER -- requirements
Module: serial_stream_feeder

---
 rtl/serial_feeder_pkg.sv | 23 ++
 rtl/piso_shift_reg.sv | 51 +++++
 rtl/serial_stream_feeder.sv | 136 +++++++++++++
 3 files changed

// File: rtl/serial_feeder_pkg.sv
// ----------------------------------------------------------------------------
//  Module   : serial_feeder_pkg
//  Brief    : FSM state encoding and parity helper for serial_stream_feeder.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package serial_feeder_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SHIFT  = 2'b01,
      PARITY = 2'b10
   } state_t;

   // Even parity over a word zero-extended to 32 bits.
   function automatic logic even_parity(input logic [31:0] word);
      return ^word;
   endfunction

endpackage

`default_nettype wire

// File: rtl/piso_shift_reg.sv
// ----------------------------------------------------------------------------
//  Module   : piso_shift_reg
//  Brief    : Parallel-in serial-out register; the head bit is the serial output.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module piso_shift_reg #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic             i_shift,
   input  logic             i_fill,
   input  logic [WIDTH-1:0] i_din,
   output logic             o_bit
);

   logic [WIDTH-1:0] r_sr;
   logic [WIDTH-1:0] w_shifted;

   // i_fill enters at the tail, so zeros shifted in leave the register empty
   // once a frame drains.
   generate
      if (WIDTH == 1) begin : g_single
         assign w_shifted = i_fill;
         assign o_bit     = r_sr[0];
      end else if (MSB_FIRST) begin : g_msb
         assign w_shifted = {r_sr[WIDTH-2:0], i_fill};
         assign o_bit     = r_sr[WIDTH-1];
      end else begin : g_lsb
         assign w_shifted = {i_fill, r_sr[WIDTH-1:1]};
         assign o_bit     = r_sr[0];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sr <= '0;
      end else if (i_load) begin
         r_sr <= i_din;
      end else if (i_shift) begin
         r_sr <= w_shifted;
      end
   end

endmodule

`default_nettype wire

// File: rtl/serial_stream_feeder.sv
// ----------------------------------------------------------------------------
//  Module   : serial_stream_feeder
//  Brief    : Serializes parallel words into a framed bit stream; rst is
//             asynchronous active-low. Define SERIAL_FEEDER_PARITY_EN to append
//             an even-parity bit to every frame.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module serial_stream_feeder
   import serial_feeder_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             dout,
   output logic             dout_valid,
   output logic             busy,
   output logic             word_done
);

   localparam int            CW         = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] c_last_bit = CW'(WIDTH - 1);

   state_t        r_state;
   state_t        w_next;
   logic [CW-1:0] r_cnt;
   logic          r_dout_valid;
   logic          w_last;
   logic          w_accept;
   logic          w_shift;
   logic          w_fill;

`ifdef SERIAL_FEEDER_PARITY_EN
   logic          r_par;
`endif

   assign w_last = (r_cnt == c_last_bit);

   always_comb begin
      w_next    = r_state;
      din_ready = 1'b0;
      word_done = 1'b0;
      w_shift   = 1'b0;
      w_fill    = 1'b0;
      case (r_state)
         IDLE: begin
            din_ready = 1'b1;
         end
         SHIFT: begin
            w_shift = 1'b1;
`ifdef SERIAL_FEEDER_PARITY_EN
            // Parity enters on the first shift and reaches the head just as the
            // data bits run out.
            if (r_cnt == '0) begin
               w_fill = r_par;
            end
            if (w_last) begin
               w_next = PARITY;
            end
`else
            if (w_last) begin
               din_ready = 1'b1;
               word_done = 1'b1;
               w_next    = IDLE;
            end
`endif
         end
`ifdef SERIAL_FEEDER_PARITY_EN
         PARITY: begin
            din_ready = 1'b1;
            word_done = 1'b1;
            w_shift   = 1'b1;
            w_next    = IDLE;
         end
`endif
         default: begin
            w_next = IDLE;
         end
      endcase
      w_accept = din_valid && din_ready;
      if (w_accept) begin
         w_next = SHIFT;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= IDLE;
         r_cnt        <= '0;
         r_dout_valid <= 1'b0;
      end else begin
         r_state      <= w_next;
         r_dout_valid <= (w_next != IDLE);
         if (w_accept) begin
            r_cnt <= '0;
         end else if (r_state == SHIFT && !w_last) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

`ifdef SERIAL_FEEDER_PARITY_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_par <= 1'b0;
      end else if (w_accept) begin
         r_par <= even_parity(32'(din));
      end
   end
`endif

   piso_shift_reg #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_piso (
      .clk     (clk),
      .rst_n   (rst),
      .i_load  (w_accept),
      .i_shift (w_shift),
      .i_fill  (w_fill),
      .i_din   (din),
      .o_bit   (dout)
   );

   assign dout_valid = r_dout_valid;
   assign busy       = (r_state != IDLE);

endmodule

`default_nettype wire
